// File: rtl/frame_sync.sv
// frame_sync: prepends a two-byte sync header to each fixed-length payload frame behind one output register.
// Define FRAME_SYNC_CSUM_EN to append an XOR checksum byte after each frame's payload.
module frame_sync #(
    parameter int                 width_p       = 8,
    parameter int                 frame_bytes_p = 3240,
    parameter logic [width_p-1:0] sync0_p       = 8'hA5,
    parameter logic [width_p-1:0] sync1_p       = 8'h5A
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i,
    output logic               frame_done_o,
    output logic [7:0]         frame_count_o
);
    localparam int cw_c = $clog2(frame_bytes_p + 1);
    localparam logic [cw_c-1:0] last_c = cw_c'(frame_bytes_p - 1);
`ifdef FRAME_SYNC_CSUM_EN
    typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, CSUM} state_e;
    localparam state_e after_payload_c = CSUM;
    localparam logic payload_tail_c = 1'b0;
    logic [width_p-1:0] csum_q;
`else
    typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD} state_e;
    localparam state_e after_payload_c = HDR0;
    localparam logic payload_tail_c = 1'b1;
`endif
    state_e state_q, state_d;
    logic [cw_c-1:0] count_q;
    logic [width_p-1:0] data_q, load_data;
    logic [7:0] fcount_q;
    logic valid_q, tail_q, done_q, free, accept, last, load, load_tail, done;

    assign free = !valid_q || ready_i;
    assign ready_o = (state_q == PAYLOAD) && free;
    assign accept = valid_i && ready_o;
    assign last = count_q == last_c;
    assign done = valid_q && ready_i && tail_q;
    assign valid_o = valid_q;
    assign data_o = data_q;
    assign frame_done_o = done_q;
    assign frame_count_o = fcount_q;

    always_ff @(posedge clk_i) state_q <= reset_i ? HDR0 : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR0:    state_d = free ? HDR1 : HDR0;
            HDR1:    state_d = free ? PAYLOAD : HDR1;
            PAYLOAD: state_d = (accept && last) ? after_payload_c : PAYLOAD;
`ifdef FRAME_SYNC_CSUM_EN
            CSUM:    state_d = free ? HDR0 : CSUM;
`endif
            default: state_d = HDR0;
        endcase
    end

    always_comb begin
        load = 1'b0;
        load_data = data_i;
        load_tail = 1'b0;
        case (state_q)
            HDR0: begin
                load = free;
                load_data = sync0_p;
            end
            HDR1: begin
                load = free;
                load_data = sync1_p;
            end
            PAYLOAD: begin
                load = accept;
                load_tail = payload_tail_c && last;
            end
`ifdef FRAME_SYNC_CSUM_EN
            CSUM: begin
                load = free;
                load_data = csum_q;
                load_tail = 1'b1;
            end
`endif
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
            valid_q <= 1'b0;
            tail_q <= 1'b0;
            count_q <= '0;
            done_q <= 1'b0;
            fcount_q <= '0;
        end else begin
            if (load) begin
                data_q <= load_data;
                valid_q <= 1'b1;
                tail_q <= load_tail;
            end else if (ready_i) begin
                valid_q <= 1'b0;
                tail_q <= 1'b0;
            end
            if (accept) count_q <= last ? '0 : count_q + cw_c'(1);
            done_q <= done;
            fcount_q <= fcount_q + 8'(done);
        end
    end

`ifdef FRAME_SYNC_CSUM_EN
    // Payload accept and checksum emission never coincide: ready_o is low in CSUM.
    always_ff @(posedge clk_i) begin
        if (reset_i) csum_q <= '0;
        else if (accept) csum_q <= csum_q ^ data_i;
        else if (state_q == CSUM && free) csum_q <= '0;
    end
`endif
endmodule

// File: tb/tb_frame_sync.sv
// tb_frame_sync: random-backpressure scoreboard bench for frame_sync with 4-byte frames.
module tb_frame_sync;
    localparam int fb_c = 4;
    typedef struct packed { logic [7:0] b; logic t; } ent_t;

    logic clk_i = 1'b0, reset_i = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
    logic [7:0] data_i = '0;
    logic ready_o, valid_o, frame_done_o;
    logic [7:0] data_o, frame_count_o;

    ent_t q[$];
    ent_t ent;
    int checks = 0, fails = 0, rdy_pct = 100, pcnt = 0;
    logic [7:0] csum = '0, exp_fc = '0, held_d = '0;
    logic done_pend = 1'b0, rst_prev = 1'b1, stall_prev = 1'b0;

    frame_sync #(.width_p(8), .frame_bytes_p(fb_c), .sync0_p(8'hA5), .sync1_p(8'h5A)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
        .frame_done_o(frame_done_o), .frame_count_o(frame_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic void push_hdr();
        q.push_back('{b: 8'hA5, t: 1'b0});
        q.push_back('{b: 8'h5A, t: 1'b0});
    endfunction

    // Reference: a frame is header, fb_c payload bytes, optional XOR byte; next header queued at once.
    function automatic void take(input logic [7:0] d);
        pcnt++;
        csum ^= d;
`ifdef FRAME_SYNC_CSUM_EN
        q.push_back('{b: d, t: 1'b0});
        if (pcnt == fb_c) q.push_back('{b: csum, t: 1'b1});
`else
        q.push_back('{b: d, t: pcnt == fb_c});
`endif
        if (pcnt == fb_c) begin
            pcnt = 0;
            csum = '0;
            push_hdr();
        end
    endfunction

    always @(negedge clk_i) begin
        if (reset_i) begin
            q.delete();
            push_hdr();
            pcnt = 0;
            csum = '0;
            exp_fc = '0;
            done_pend = 1'b0;
            stall_prev = 1'b0;
            rst_prev = 1'b1;
        end else begin
            if (rst_prev) begin
                chk("reset valid_o", valid_o, 0);
                chk("reset data_o", data_o, 0);
                chk("reset ready_o", ready_o, 0);
            end
            rst_prev = 1'b0;
            if (done_pend) exp_fc++;
            chk("frame_done_o", frame_done_o, done_pend);
            chk("frame_count_o", frame_count_o, exp_fc);
            done_pend = 1'b0;
            if (stall_prev) begin
                chk("hold valid_o", valid_o, 1);
                chk("hold data_o", data_o, held_d);
            end
            stall_prev = valid_o && !ready_i;
            held_d = data_o;
            if (valid_i && ready_o) take(data_i);
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL extra byte: got %0h, expected none at %0t", data_o, $time);
                end else begin
                    ent = q.pop_front();
                    chk("data_o", data_o, ent.b);
                    done_pend = ent.t;
                end
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        ready_i = $urandom_range(99) < rdy_pct;
    end

    task automatic send(input logic [7:0] d, input int gap);
        int n = 0;
        logic hs = 1'b0;
        valid_i = 1'b1;
        data_i = d;
        while (!hs) begin
            @(negedge clk_i);
            hs = ready_o;
            @(posedge clk_i);
            #1;
            if (++n > 200 && !hs) begin
                checks++;
                fails++;
                $display("FAIL send timeout: got no ready_o, expected handshake for %0h", d);
                hs = 1'b1;
            end
        end
        valid_i = 1'b0;
        repeat (gap) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic frame(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        frame(32'h01020304, 0);
        frame(32'h10111213, 0);
        frame(32'h20212223, 0);
        rdy_pct = 50;
        for (int k = 0; k < 3; k++) frame($urandom, 0);
        rdy_pct = 100;
        frame(32'h30313233, 3);
        frame(32'hA55AA5FF, 0);
        rdy_pct = 70;
        frame($urandom, 1);
        send(8'h41, 0);
        send(8'h42, 0);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        rdy_pct = 100;
        frame(32'h50515253, 0);
        repeat (20) @(posedge clk_i);
        #1;
        chk("drained queue", q.size(), 0);
        chk("idle ready_o", ready_o, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
